// File: rtl/regfile_pkg.sv
// Shared register-file constants and the debug-dump FSM state encoding.
package regfile_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } dump_state_e;

endpackage

// File: rtl/dump_out_stage.sv
// One-entry valid/ready output register for the register-file dump stream.
module dump_out_stage #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] index_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] index_o,
  output logic [DATA_W-1:0] data_o,
  output logic              can_load_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Loading is allowed when empty or when the held word leaves this cycle.
  assign can_load_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    index_d = index_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      index_d = index_i;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      index_q <= index_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign index_o = index_q;
  assign data_o  = data_q;

endmodule

// File: rtl/regfile_dump.sv
// Debug reader: walks a wrap-around register index range through one read
// port and streams {index, data} pairs over a valid/ready link.
module regfile_dump
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int unsigned ADDR_W   = regfile_pkg::REG_ADDR_W,
  parameter int unsigned DATA_W   = regfile_pkg::REG_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_index,
  output logic [DATA_W-1:0] dump_data
);

  localparam int unsigned CNT_W = $clog2(NUM_REGS + 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] span;
  logic              can_load;
  logic              load;

  // Index arithmetic wraps naturally at ADDR_W bits, i.e. mod NUM_REGS.
  assign span = last_reg - first_reg;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = first_reg;
          rem_d   = CNT_W'(span) + CNT_W'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        addr_d = idx_q;
        if (rem_q != '0 && can_load) begin
          load  = 1'b1;
          idx_d = idx_q + ADDR_W'(1);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dump_valid && dump_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  // Live index while walking; otherwise hold the last address presented.
  assign rf_read_addr = (state_q == RUN) ? idx_q : addr_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

  dump_out_stage #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .index_i    (idx_q),
    .data_i     (rf_read_data),
    .ready_i    (dump_ready),
    .valid_o    (dump_valid),
    .index_o    (dump_index),
    .data_o     (dump_data),
    .can_load_o (can_load)
  );

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump against a preloaded register-file model.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic        busy;
  logic        done;
  logic [4:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_index;
  logic [31:0] dump_data;

  logic [31:0] regs [32];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  // Observations gathered by collect()
  logic [4:0]  q_idx[$];
  logic [31:0] q_dat[$];
  int          start_cyc;
  int          n_done;
  int          done_rel;
  int          first_valid_rel;
  int          stall_err;
  int          stall_cycles;
  bit          timeout;
  logic        busy_t1;
  logic [15:0] pat = 16'b1011_0010_1100_0110;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rf_read_data = regs[rf_read_addr];

  regfile_dump #(
    .NUM_REGS (32),
    .ADDR_W   (5),
    .DATA_W   (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .first_reg    (first_reg),
    .last_reg     (last_reg),
    .busy         (busy),
    .done         (done),
    .rf_read_addr (rf_read_addr),
    .rf_read_data (rf_read_data),
    .dump_valid   (dump_valid),
    .dump_ready   (dump_ready),
    .dump_index   (dump_index),
    .dump_data    (dump_data)
  );

  task automatic pulse_start(input logic [4:0] f, input logic [4:0] l);
    @(posedge clk); #1;
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs from cycle T+1 until 3 cycles after done, a word budget, or max_cyc.
  task automatic collect(input int max_cyc, input bit use_pat, input int restart_at,
                         input int stop_words);
    bit          have_hold = 1'b0;
    bit          fin = 1'b0;
    logic [4:0]  hold_idx = '0;
    logic [31:0] hold_dat = '0;
    int          k = 0;
    q_idx.delete();
    q_dat.delete();
    n_done = 0; done_rel = -1; first_valid_rel = -1;
    stall_err = 0; stall_cycles = 0; timeout = 1'b0;
    dump_ready = use_pat ? pat[cyc % 16] : 1'b1;
    while (!fin && k < max_cyc) begin
      @(negedge clk);
      if (k == 0) busy_t1 = busy;
      if (dump_valid && first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
      if (have_hold && (!dump_valid || dump_index !== hold_idx || dump_data !== hold_dat))
        stall_err++;
      have_hold = dump_valid && !dump_ready;
      if (have_hold) stall_cycles++;
      hold_idx = dump_index;
      hold_dat = dump_data;
      if (dump_valid && dump_ready) begin
        q_idx.push_back(dump_index);
        q_dat.push_back(dump_data);
      end
      if (done) begin
        n_done++;
        if (done_rel < 0) done_rel = cyc - start_cyc;
      end
      @(posedge clk); #1;
      start = (restart_at > 0 && (cyc - start_cyc) == restart_at);
      dump_ready = use_pat ? pat[cyc % 16] : 1'b1;
      if (stop_words > 0 && q_idx.size() >= stop_words) fin = 1'b1;
      if (done_rel >= 0 && (cyc - start_cyc) >= done_rel + 3) fin = 1'b1;
      k++;
    end
    start = 1'b0;
    if (stop_words > 0) timeout = (q_idx.size() < stop_words);
    else                timeout = (done_rel < 0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; dump_ready = 1'b0;
    first_reg = '0; last_reg = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, dump_valid} !== 3'b000 || dump_index !== 5'd0 ||
        dump_data !== 32'd0 || rf_read_addr !== 5'd0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b valid=%b idx=%0d data=%h addr=%0d, required all 0",
               busy, done, dump_valid, dump_index, dump_data, rf_read_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_full_range;
    int bad = 0;
    pulse_start(5'd0, 5'd31);
    collect(100, 1'b0, 0, 0);
    checks++;
    if (timeout) begin failures++; $display("FAIL full_timeout: done not seen, required within 100 cycles"); end
    checks++;
    if (busy_t1 !== 1'b1) begin failures++; $display("FAIL full_busy_t1: got %b, required 1", busy_t1); end
    checks++;
    if (first_valid_rel != 2) begin failures++; $display("FAIL full_first_valid: got T+%0d, required T+2", first_valid_rel); end
    checks++;
    if (q_idx.size() != 32) begin failures++; $display("FAIL full_count: got %0d words, required 32", q_idx.size()); end
    for (int i = 0; i < q_idx.size() && i < 32; i++)
      if (q_idx[i] !== 5'(i) || q_dat[i] !== 32'h1000_0000 + 32'(i)) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL full_words: got %0d wrong words, required 0", bad); end
    checks++;
    if (done_rel != 34) begin failures++; $display("FAIL full_done_time: got T+%0d, required T+34", done_rel); end
    checks++;
    if (busy !== 1'b0 || rf_read_addr !== 5'd31) begin
      failures++;
      $display("FAIL full_idle_after: busy=%b addr=%0d, required busy=0 addr=31", busy, rf_read_addr);
    end
  endtask

  task automatic test_wrap;
    int bad = 0;
    logic [4:0] e;
    pulse_start(5'd30, 5'd1);
    collect(50, 1'b0, 0, 0);
    checks++;
    if (q_idx.size() != 4) begin failures++; $display("FAIL wrap_count: got %0d words, required 4", q_idx.size()); end
    for (int i = 0; i < q_idx.size() && i < 4; i++) begin
      e = 5'(30 + i);
      if (q_idx[i] !== e || q_dat[i] !== 32'h1000_0000 + 32'(e)) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL wrap_words: got %0d wrong words, required 0", bad); end
    checks++;
    if (done_rel != 6 || n_done != 1) begin
      failures++;
      $display("FAIL wrap_done: got T+%0d count %0d, required T+6 count 1", done_rel, n_done);
    end
  endtask

  task automatic test_single;
    pulse_start(5'd5, 5'd5);
    collect(30, 1'b0, 0, 0);
    checks++;
    if (q_idx.size() != 1 || q_idx[0] !== 5'd5 || q_dat[0] !== 32'h1000_0005) begin
      failures++;
      $display("FAIL single_word: got %0d words first idx=%0d, required one word (5, 10000005)",
               q_idx.size(), q_idx.size() > 0 ? q_idx[0] : 5'd0);
    end
    checks++;
    if (done_rel != 3) begin failures++; $display("FAIL single_done_time: got T+%0d, required T+3", done_rel); end
    checks++;
    if (rf_read_addr !== 5'd5) begin failures++; $display("FAIL single_addr_hold: got %0d, required 5", rf_read_addr); end
  endtask

  task automatic test_backpressure;
    int bad = 0;
    pulse_start(5'd0, 5'd7);
    collect(200, 1'b1, 0, 0);
    checks++;
    if (timeout || q_idx.size() != 8) begin
      failures++;
      $display("FAIL bp_count: got %0d words timeout=%b, required 8 words", q_idx.size(), timeout);
    end
    for (int i = 0; i < q_idx.size() && i < 8; i++)
      if (q_idx[i] !== 5'(i) || q_dat[i] !== 32'h1000_0000 + 32'(i)) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_words: got %0d wrong words, required 0", bad); end
    checks++;
    if (stall_err != 0 || stall_cycles == 0) begin
      failures++;
      $display("FAIL bp_stable: got %0d unstable of %0d stalls, required 0 unstable of >0",
               stall_err, stall_cycles);
    end
    checks++;
    if (n_done != 1) begin failures++; $display("FAIL bp_done: got %0d done pulses, required 1", n_done); end
  endtask

  task automatic test_restart_ignored;
    int bad = 0;
    pulse_start(5'd0, 5'd15);
    first_reg = 5'd20;
    last_reg  = 5'd21;
    collect(100, 1'b0, 5, 0);
    checks++;
    if (q_idx.size() != 16) begin failures++; $display("FAIL restart_count: got %0d words, required 16", q_idx.size()); end
    for (int i = 0; i < q_idx.size() && i < 16; i++)
      if (q_idx[i] !== 5'(i) || q_dat[i] !== 32'h1000_0000 + 32'(i)) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL restart_words: got %0d wrong words, required 0", bad); end
    checks++;
    if (n_done != 1 || done_rel != 18) begin
      failures++;
      $display("FAIL restart_done: got count %0d at T+%0d, required 1 at T+18", n_done, done_rel);
    end
  endtask

  task automatic test_reset_mid_dump;
    int dones = 0;
    int bad = 0;
    pulse_start(5'd0, 5'd31);
    collect(100, 1'b0, 0, 3);
    rst_n = 1'b0;
    #1;
    checks++;
    if (timeout || {busy, done, dump_valid} !== 3'b000 || dump_index !== 5'd0 ||
        dump_data !== 32'd0 || rf_read_addr !== 5'd0) begin
      failures++;
      $display("FAIL midreset_outputs: busy=%b done=%b valid=%b idx=%0d data=%h addr=%0d timeout=%b, required all 0",
               busy, done, dump_valid, dump_index, dump_data, rf_read_addr, timeout);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones != 0 || n_done != 0) begin
      failures++;
      $display("FAIL midreset_no_done: got %0d done pulses, required 0", dones + n_done);
    end
    pulse_start(5'd4, 5'd6);
    collect(50, 1'b0, 0, 0);
    for (int i = 0; i < q_idx.size() && i < 3; i++)
      if (q_idx[i] !== 5'(4 + i) || q_dat[i] !== 32'h1000_0004 + 32'(i)) bad++;
    checks++;
    if (q_idx.size() != 3 || bad != 0 || done_rel != 5) begin
      failures++;
      $display("FAIL midreset_redump: got %0d words %0d wrong done T+%0d, required 3 words 0 wrong done T+5",
               q_idx.size(), bad, done_rel);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
    test_reset();
    test_full_range();
    test_wrap();
    test_single();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug-side reader for the 32 x 32-bit MIPS register file. On a start pulse it walks a programmable, wrap-around range of register indices through one register-file read port and streams each `{index, data}` pair out over a valid/ready interface at up to one word per cycle. It sits between the register file's second read port (muxed in while the core is halted) and the debug/trace link.

## Interface
- `NUM_REGS`, 32, number of architectural registers
- `ADDR_W`, 5, register index width, log2(`NUM_REGS`)
- `DATA_W`, 32, register data width
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin a dump; ignored unless idle
- `first_reg`  in  `ADDR_W`  first index to dump; sampled on an accepted `start`
- `last_reg`  in  `ADDR_W`  last index to dump; sampled on an accepted `start`
- `busy`  out  1  high from the cycle after an accepted `start` until the `done` cycle, inclusive
- `done`  out  1  one-cycle pulse after the final word is accepted
- `rf_read_addr`  out  `ADDR_W`  register-file read address
- `rf_read_data`  in  `DATA_W`  register-file read data, combinational from `rf_read_addr`
- `dump_valid`  out  1  output word valid
- `dump_ready`  in  1  downstream accepts
- `dump_index`  out  `ADDR_W`  register index of the current word
- `dump_data`  out  `DATA_W`  register value of the current word

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on `start`, latch `idx = first_reg` and `remaining = ((last_reg - first_reg) mod NUM_REGS) + 1`, giving a count of 1..32. Go to RUN.
- `first_reg > last_reg` wraps. For example, 30..1 dumps 30, 31, 0, 1. `first_reg == last_reg` dumps exactly one register.
- `rf_read_addr = idx` in RUN. It holds its last value in every other state and is 0 after reset.
- The output stage is a one-entry register. It "can load" when it is empty, or when `dump_valid && dump_ready` in the same cycle.
- RUN with `remaining != 0` and can load: capture `rf_read_data` and `idx` into `dump_data` and `dump_index`, set `dump_valid`, then `idx <= idx + 1` (mod 32) and `remaining <= remaining - 1`.
- When `remaining` reaches 0 after a capture, go to DRAIN.
- DRAIN: when the final word is accepted, clear `dump_valid` and go to DONE.
- DONE: assert `done` for one cycle, return to IDLE.
- `dump_data` and `dump_index` must stay stable while `dump_valid && !dump_ready`. `dump_valid` never drops without a handshake.
- Data reflects the register-file contents in the capture cycle. There is no snapshot guarantee if the core writes during a dump.
- `start` during RUN, DRAIN or DONE is ignored; the range is not re-sampled.
- Reset mid-dump: `rst_n` low immediately forces IDLE. All outputs go to reset values. No `done` is issued.

## Timing
- Reset values: `busy` 0, `done` 0, `dump_valid` 0, `dump_index` 0, `dump_data` 0, `rf_read_addr` 0.
- `start` at cycle T:
  - `busy` = 1 and RUN at T+1.
  - First capture at the T+1 edge, so `dump_valid` = 1 at T+2.
- With `dump_ready` held high, N words occupy cycles T+2 .. T+N+1 back-to-back.
- The last word is accepted at cycle T+N+1. `done` = 1 at T+N+2, and `busy` falls at T+N+3.
- Backpressure stalls `idx`; no word is skipped or duplicated.

## Structure
- Shared package `regfile_pkg`:
  - `NUM_REGS`, `REG_ADDR_W`, `REG_DATA_W`, shared with the register file.
  - `dump_state_e` enum (IDLE, RUN, DRAIN, DONE).
- One sub-module: `dump_out_stage`, the one-entry valid/ready output register with a `can_load` output. The FSM, index counter and remaining counter live in the top module.

## Test plan
- Register file preloaded with `reg[i] = 0x1000_0000 + i`. Dump range 0..31 with `dump_ready` = 1:
  - 32 consecutive words, index 0..31, data 0x1000_0000..0x1000_001F.
  - `done` exactly 34 cycles after `start`.
- Range 30..1: words (30, 0x1000_001E), (31, 0x1000_001F), (0, 0x1000_0000), (1, 0x1000_0001), then `done`.
- Range 5..5: exactly one word (5, 0x1000_0005). `done` 3 cycles after `start`.
- Range 0..7 with `dump_ready` toggled pseudo-randomly:
  - Exactly 8 words, in order, with no duplicates.
  - `dump_data` and `dump_index` stable across every stalled cycle.
- `start` pulsed again mid-dump of 0..15: ignored, still exactly 16 words and one `done`.
- `rst_n` asserted after the 3rd accepted word of 0..31: all outputs 0 on the same cycle and no `done`. A new `start` after release dumps correctly from `first_reg`.
